tile_renderer: RTL and testbench

- Display-side consumer of the double-buffered tile-index memory.
- Maps each requested screen pixel to a tile-index word address, then reads the display buffer.
- Resolves the tile's pixel through the tile ROM and emits 24-bit RGB.
- Owns the buffer-select control (tile_idx_select). Swaps buffers only at frame end, with no display read in flight, so the RPi writer never tears a displayed frame.

---
 rtl/tile_renderer_if.sv | 40 ++++
 rtl/tile_renderer.sv | 155 +++++++++++++++
 tb/tb_tile_renderer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_renderer_if.sv
// tile_renderer_if
//   Bundles every non-clock/reset signal of tile_renderer: the pixel
//   request stream, the display-buffer and tile-ROM read ports, the RGB
//   output and the buffer-swap handshake.
//   Modports:
//     slave  - the renderer (consumes pixel requests and memory data,
//              drives addresses, RGB and buffer-select).
//     master - the surrounding environment (video timing, memories, RPi side).
interface tile_renderer_if #(
    parameter int ADDR_WIDTH      = 12,
    parameter int TILE_ADDR_WIDTH = 14
);
    logic                       pix_valid;
    logic [10:0]                pix_x;
    logic [9:0]                 pix_y;
    logic                       frame_end;
    logic [ADDR_WIDTH-1:0]      tile_idx_display_addr;
    logic [31:0]                tile_idx_display_rd;
    logic [TILE_ADDR_WIDTH-1:0] tile_rom_addr;
    logic [23:0]                tile_rom_rd;
    logic                       rgb_valid;
    logic [23:0]                rgb;
    logic                       swap_req;
    logic                       swap_done;
    logic                       tile_idx_select;

    modport slave (
        input  pix_valid, pix_x, pix_y, frame_end,
        input  tile_idx_display_rd, tile_rom_rd, swap_req,
        output tile_idx_display_addr, tile_rom_addr,
        output rgb_valid, rgb, swap_done, tile_idx_select
    );

    modport master (
        output pix_valid, pix_x, pix_y, frame_end,
        output tile_idx_display_rd, tile_rom_rd, swap_req,
        input  tile_idx_display_addr, tile_rom_addr,
        input  rgb_valid, rgb, swap_done, tile_idx_select
    );
endinterface

// File: rtl/tile_renderer.sv
// tile_renderer
//   Display-side consumer of the double-buffered tile-index memory.
//   Each requested pixel is mapped to a tile-index word address, the display
//   buffer is read, the tile pixel is fetched from the tile ROM and emitted
//   as 24-bit RGB with a fixed 4-cycle latency at one pixel per cycle.
//   Also owns the display buffer select, which only toggles after a frame
//   end and once no display read is in flight.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - tile_renderer_if.slave: pix_valid/pix_x/pix_y/frame_end in,
//          tile_idx_display_addr/_rd, tile_rom_addr/_rd memory ports,
//          rgb_valid/rgb out, swap_req in, swap_done/tile_idx_select out.
// Build option:
//   TILE_RENDER_FLIP_EN - when defined, tile word bit 24 mirrors X and
//   bit 25 mirrors Y inside the tile; when undefined those bits are ignored.
module tile_renderer #(
    parameter int ADDR_WIDTH      = 12,
    parameter int H_TILES         = 100,
    parameter int TILE_ADDR_WIDTH = 14
) (
    input logic            clk,
    input logic            rst,
    tile_renderer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        DRAIN
    } swap_state_t;

    swap_state_t state, state_nxt;
    logic        do_swap;
    logic        select_q;
    logic        swap_done_q;

    // Pipeline state
    logic [ADDR_WIDTH-1:0]      disp_addr_q;
    logic [ADDR_WIDTH-1:0]      disp_addr_nxt;
    logic                       v1, v2, v3, v4;
    logic [2:0]                 rx1, ry1, rx2, ry2;
    logic [2:0]                 rx_eff, ry_eff;
    logic [TILE_ADDR_WIDTH-1:0] rom_addr_q;
    logic                       rgb_valid_q;
    logic [23:0]                rgb_q;

    logic [31:0] word;
    logic        unused_word_bits;

    assign word             = bus.tile_idx_display_rd;
    assign unused_word_bits = ^word;

    // Arithmetic is done at ADDR_WIDTH bits, so the result is already the
    // tile-row/column address truncated modulo 2^ADDR_WIDTH.
    always_comb begin
        disp_addr_nxt = ADDR_WIDTH'(bus.pix_y[9:3]) * ADDR_WIDTH'(H_TILES)
                      + ADDR_WIDTH'(bus.pix_x[10:3]);
    end

    // In-tile coordinates used for the ROM address.
    always_comb begin
        rx_eff = rx2;
        ry_eff = ry2;
`ifdef TILE_RENDER_FLIP_EN
        if (word[24]) rx_eff = ~rx2;   // 7 - rx
        if (word[25]) ry_eff = ~ry2;   // 7 - ry
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_addr_q <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            v4          <= 1'b0;
            rx1         <= '0;
            ry1         <= '0;
            rx2         <= '0;
            ry2         <= '0;
            rom_addr_q  <= '0;
            rgb_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            // Stage 1: display-buffer address.
            v1 <= bus.pix_valid;
            if (bus.pix_valid) begin
                disp_addr_q <= disp_addr_nxt;
                rx1         <= bus.pix_x[2:0];
                ry1         <= bus.pix_y[2:0];
            end
            // Stage 2: RAM capturing the address; coordinates travel along.
            v2  <= v1;
            rx2 <= rx1;
            ry2 <= ry1;
            // Stage 3: tile ROM address from the returned word.
            v3 <= v2;
            if (v2)
                rom_addr_q <= {word[TILE_ADDR_WIDTH-7:0], ry_eff, rx_eff};
            // Stage 4: ROM capturing the address.
            v4 <= v3;
            // Stage 5: RGB out; holds its value while not valid.
            rgb_valid_q <= v4;
            if (v4)
                rgb_q <= bus.tile_rom_rd;
        end
    end

    // Swap FSM: next state
    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.swap_req)
                    state_nxt = PENDING;
            end
            PENDING: begin
                if (bus.frame_end)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // A pixel being sampled on the toggle edge would read the
                // display RAM one edge later, so it also holds off the swap.
                if (!v1 && !v2 && !bus.pix_valid) begin
                    do_swap   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Swap FSM: state register and registered select / done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            select_q    <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            select_q    <= select_q ^ do_swap;
            swap_done_q <= do_swap;
        end
    end

    assign bus.tile_idx_display_addr = disp_addr_q;
    assign bus.tile_rom_addr         = rom_addr_q;
    assign bus.rgb_valid             = rgb_valid_q;
    assign bus.rgb                   = rgb_q;
    assign bus.swap_done             = swap_done_q;
    assign bus.tile_idx_select       = select_q;

endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer
//   Self-checking bench for tile_renderer. Directed pixels are issued and
//   their expected RGB plus expected output cycle are queued; a monitor
//   pops and compares whenever rgb_valid is seen. Behavioural display RAM
//   (two buffers) and tile ROM with 1-cycle read latency surround the DUT.
module tb_tile_renderer;
    localparam int AW  = 12;
    localparam int HT  = 100;
    localparam int TAW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_renderer_if #(.ADDR_WIDTH(AW), .TILE_ADDR_WIDTH(TAW)) bus ();

    tile_renderer #(.ADDR_WIDTH(AW), .H_TILES(HT), .TILE_ADDR_WIDTH(TAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:1][0:4095];
    logic [23:0] rom [0:16383];

    always @(posedge clk) begin
        bus.tile_idx_display_rd <= ram[bus.tile_idx_select][bus.tile_idx_display_addr];
        bus.tile_rom_rd         <= rom[bus.tile_rom_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int swap_cnt = 0;
    int last_swap_cyc = 0;
    logic exp_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] rgb;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model(input logic [10:0] x, input logic [9:0] y, input logic s);
        logic [AW-1:0]  a;
        logic [31:0]    w;
        logic [2:0]     rx, ry;
        logic [TAW-1:0] ra;
        a  = AW'((int'(y) / 8) * HT + int'(x) / 8);
        w  = ram[s][a];
        rx = x[2:0];
        ry = y[2:0];
`ifdef TILE_RENDER_FLIP_EN
        if (w[24]) rx = 3'd7 - rx;
        if (w[25]) ry = 3'd7 - ry;
`endif
        ra = {w[TAW-7:0], ry, rx};
        return rom[ra];
    endfunction

    // Drive one cycle of inputs (sampled at the next posedge); queue the
    // expected pixel if one is issued.
    task automatic step(input logic pv, input int x, input int y, input logic fe, input logic sr);
        exp_t e;
        @(negedge clk);
        bus.pix_valid = pv;
        bus.pix_x     = 11'(x);
        bus.pix_y     = 10'(y);
        bus.frame_end = fe;
        bus.swap_req  = sr;
        if (pv) begin
            e.rgb = model(11'(x), 10'(y), exp_sel);
            e.cyc = cyc + 1 + 4;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (q.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rgb_valid) begin
            if (q.size() == 0) begin
                chk("rgb_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rgb", 32'(bus.rgb), 32'(e.rgb));
                chk("rgb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (bus.swap_done) begin
            swap_cnt++;
            last_swap_cyc = cyc;
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_disp_addr"}, 32'(bus.tile_idx_display_addr), 32'd0);
        chk({nm, "_rom_addr"},  32'(bus.tile_rom_addr), 32'd0);
        chk({nm, "_rgb_valid"}, 32'(bus.rgb_valid), 32'd0);
        chk({nm, "_rgb"},       32'(bus.rgb), 32'd0);
        chk({nm, "_swap_done"}, 32'(bus.swap_done), 32'd0);
        chk({nm, "_select"},    32'(bus.tile_idx_select), 32'd0);
    endtask

    initial begin
        int fe_cyc;
        int b_cyc;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 4096; a++)
                ram[b][a] = {6'd0, 2'(a), 16'd0, 8'(a + b * 64)};
        for (int i = 0; i < 16384; i++)
            rom[i] = {8'(i >> 6) ^ 8'h3C, 6'(i), 2'b01, 8'(i) ^ 8'hC3};
        ram[0][102] = 32'h0000_0005;
        rom[329]    = 24'hFF8000;
        rom[334]    = 24'hFF8000;

        bus.pix_valid = 1'b0;
        bus.pix_x     = '0;
        bus.pix_y     = '0;
        bus.frame_end = 1'b0;
        bus.swap_req  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst = 1'b0;
        idle(10);
        chk_all_zero("after_reset");
        chk("no_swap_after_reset", 32'(swap_cnt), 32'd0);

        // Directed pixel (17,9), word 0x5
        step(1'b1, 17, 9, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        chk("disp_addr_17_9", 32'(bus.tile_idx_display_addr), 32'd102);
        idle(2);
        chk("rom_addr_17_9", 32'(bus.tile_rom_addr), 32'd329);
        idle(4);
        chk("rgb_hold_value", 32'(bus.rgb), 32'hFF8000);
        chk("rgb_hold_valid", 32'(bus.rgb_valid), 32'd0);
        chk("disp_addr_hold", 32'(bus.tile_idx_display_addr), 32'd102);
        wait_empty();

        // Same pixel with flip-X bit set in the word
        ram[0][102] = 32'h0100_0005;
        step(1'b1, 17, 9, 1'b0, 1'b0);
        idle(3);
`ifdef TILE_RENDER_FLIP_EN
        chk("rom_addr_flip", 32'(bus.tile_rom_addr), 32'd334);
`else
        chk("rom_addr_noflip", 32'(bus.tile_rom_addr), 32'd329);
`endif
        idle(4);
        wait_empty();

        // 200 back-to-back pixels
        for (int i = 0; i < 200; i++)
            step(1'b1, (i * 13 + 5) % 2048, (i * 7 + 3) % 1024, 1'b0, 1'b0);
        idle(6);
        wait_empty();

        // Swap request, frame end 50 cycles later
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(50);
        chk("select_before_frame_end", 32'(bus.tile_idx_select), 32'd0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        fe_cyc = cyc + 1;
        idle(6);
        chk("select_after_swap", 32'(bus.tile_idx_select), 32'd1);
        chk("swap_done_count_1", 32'(swap_cnt), 32'd1);
        chk("swap_within_3", 32'((last_swap_cyc - fe_cyc) >= 1 && (last_swap_cyc - fe_cyc) <= 3), 32'd1);
        exp_sel = 1'b1;

        // Frame end without request: no change
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);
        chk("select_held_1", 32'(bus.tile_idx_select), 32'd1);
        chk("swap_done_count_still_1", 32'(swap_cnt), 32'd1);

        // swap_req and frame_end together in IDLE: wait for next frame end
        step(1'b0, 0, 0, 1'b1, 1'b1);
        idle(6);
        chk("select_same_cycle_req_fe", 32'(bus.tile_idx_select), 32'd1);
        chk("swap_count_same_cycle", 32'(swap_cnt), 32'd1);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);
        chk("select_back_to_0", 32'(bus.tile_idx_select), 32'd0);
        chk("swap_done_count_2", 32'(swap_cnt), 32'd2);
        exp_sel = 1'b0;

        // Frame end while pixels are in stages 1-2: they must read buffer 0
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 40, 24, 1'b0, 1'b0);
        step(1'b1, 305, 77, 1'b1, 1'b0);
        b_cyc = cyc + 1;
        idle(8);
        chk("select_after_inflight_swap", 32'(bus.tile_idx_select), 32'd1);
        chk("swap_done_count_3", 32'(swap_cnt), 32'd3);
        chk("swap_after_ram_read", 32'(last_swap_cyc > b_cyc + 1), 32'd1);
        wait_empty();
        exp_sel = 1'b1;
        step(1'b1, 40, 24, 1'b0, 1'b0);
        step(1'b1, 305, 77, 1'b0, 1'b0);
        idle(6);
        wait_empty();

        // Reset while a swap is pending
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("select_in_reset", 32'(bus.tile_idx_select), 32'd0);
        chk("swap_done_in_reset", 32'(bus.swap_done), 32'd0);
        rst = 1'b0;
        exp_sel = 1'b0;
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);
        chk("select_after_reset_pending", 32'(bus.tile_idx_select), 32'd0);
        chk("no_swap_after_reset_pending", 32'(swap_cnt), 32'd3);
        step(1'b1, 999, 500, 1'b0, 1'b0);
        idle(6);
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
